bp_me_stream_to_burst: RTL and testbench



---
 rtl/bp_me_pkg.sv | 35 +++
 rtl/bp_me_stream_beat_counter.sv | 38 +++
 rtl/bp_me_stream_to_burst.sv | 144 ++++++++++++++
 tb/tb_bp_me_stream_to_burst.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// Shared BedRock stream/burst types: converter FSM states, header low fields, config helpers.
// Header layout, LSB first: msg_type, msg_size, paddr, payload.
package bp_me_pkg;

   typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

   typedef enum logic [0:0] {e_first, e_stream} bp_me_stream_to_burst_state_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1,
      e_bedrock_msg_size_2,
      e_bedrock_msg_size_4,
      e_bedrock_msg_size_8,
      e_bedrock_msg_size_16,
      e_bedrock_msg_size_32,
      e_bedrock_msg_size_64,
      e_bedrock_msg_size_128
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      bp_bedrock_msg_size_e msg_size;
      logic [3:0]           msg_type;
   } bp_bedrock_hdr_lo_s;

   localparam int dword_width_gp    = 64;
   localparam int cce_block_width_p = 512;

   function automatic int bp_paddr_width(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return 40;
         default:          return 40;
      endcase
   endfunction

endpackage

// File: rtl/bp_me_stream_beat_counter.sv
// Beat counter: counts data handshakes within a message and flags the beat msg_size says is final.
// Registered count, combinational is_last; no flow control of its own.
module bp_me_stream_beat_counter
   import bp_me_pkg::*;
#(
   parameter int data_width_p  = dword_width_gp,
   parameter int block_width_p = cce_block_width_p,
   localparam int cnt_width_lp = $clog2(block_width_p / data_width_p) + 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  bp_bedrock_msg_size_e    i_size,
   input  logic                    i_inc,
   input  logic                    i_clr,
   output logic [cnt_width_lp-1:0] o_cnt,
   output logic                    o_is_last
);

   logic [cnt_width_lp-1:0] r_cnt;
   logic [31:0]             w_beats;
   logic [cnt_width_lp-1:0] w_last_idx;

   // Messages narrower than one beat still occupy a full beat.
   assign w_beats    = (32'd8 << i_size) / 32'(data_width_p);
   assign w_last_idx = (w_beats == 32'd0) ? '0 : cnt_width_lp'(w_beats - 32'd1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= i_clr ? '0 : r_cnt + cnt_width_lp'(1);
      end
   end

   assign o_cnt     = r_cnt;
   assign o_is_last = (r_cnt == w_last_idx);

endmodule

// File: rtl/bp_me_stream_to_burst.sv
// Stream-to-burst converter: zero-latency pass-through, header sent once per message, every beat forwarded.
// Input stalls until all required burst handshakes for the beat complete; BP_ME_STREAM_TO_BURST_CHECK_EN adds sticky error_o.
module bp_me_stream_to_burst
   import bp_me_pkg::*;
#(
   parameter bp_params_e  bp_params_p     = e_bp_default_cfg,
   parameter int          data_width_p    = dword_width_gp,
   parameter int          payload_width_p = 8,
   parameter int          block_width_p   = cce_block_width_p,
   parameter logic [15:0] payload_mask_p  = '0,
   localparam int bp_header_width_lp = payload_width_p + bp_paddr_width(bp_params_p)
                                       + $bits(bp_bedrock_hdr_lo_s)
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic [bp_header_width_lp-1:0] in_msg_header_i,
   input  logic [data_width_p-1:0]       in_msg_data_i,
   input  logic                          in_msg_v_i,
   input  logic                          in_msg_last_i,
   output logic                          in_msg_ready_and_o,
   output logic [bp_header_width_lp-1:0] out_msg_header_o,
   output logic                          out_msg_header_v_o,
   output logic                          out_msg_has_data_o,
   input  logic                          out_msg_header_ready_and_i,
   output logic [data_width_p-1:0]       out_msg_data_o,
   output logic                          out_msg_data_v_o,
   output logic                          out_msg_last_o,
`ifdef BP_ME_STREAM_TO_BURST_CHECK_EN
   output logic                          error_o,
`endif
   input  logic                          out_msg_data_ready_and_i
);

   localparam int cnt_width_lp = $clog2(block_width_p / data_width_p) + 1;

   bp_me_stream_to_burst_state_e r_state, w_state_nxt;
   logic                    r_hdr_done, r_data_done;
   bp_bedrock_hdr_lo_s      w_hdr_lo;
   logic                    w_has_data, w_in_v, w_hdr_v, w_data_v, w_in_rdy;
   logic                    w_hdr_hs, w_data_hs, w_in_hs;
   logic [cnt_width_lp-1:0] w_cnt;
   logic                    w_is_last;

   assign w_hdr_lo   = bp_bedrock_hdr_lo_s'(in_msg_header_i[$bits(bp_bedrock_hdr_lo_s)-1:0]);
   assign w_has_data = payload_mask_p[w_hdr_lo.msg_type];
   // Reset also gates the combinational path so no valid or ready escapes while it is held.
   assign w_in_v     = in_msg_v_i & reset_n_i;

   always_comb begin
      w_state_nxt = r_state;
      w_hdr_v     = 1'b0;
      w_data_v    = 1'b0;
      w_in_rdy    = 1'b0;
      case (r_state)
         e_first: begin
            w_hdr_v  = w_in_v & ~r_hdr_done;
            w_data_v = w_in_v & w_has_data & ~r_data_done;
            w_in_rdy = reset_n_i & (r_hdr_done | out_msg_header_ready_and_i)
                       & (~w_has_data | r_data_done | out_msg_data_ready_and_i);
            if (w_in_v & w_in_rdy & w_has_data & ~in_msg_last_i) begin
               w_state_nxt = e_stream;
            end
         end
         e_stream: begin
            w_data_v = w_in_v;
            w_in_rdy = reset_n_i & out_msg_data_ready_and_i;
            if (w_in_v & w_in_rdy & in_msg_last_i) begin
               w_state_nxt = e_first;
            end
         end
         default: w_state_nxt = e_first;
      endcase
   end

   assign w_hdr_hs  = w_hdr_v & out_msg_header_ready_and_i;
   assign w_data_hs = w_data_v & out_msg_data_ready_and_i;
   assign w_in_hs   = w_in_v & w_in_rdy;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= e_first;
         r_hdr_done  <= 1'b0;
         r_data_done <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_in_hs) begin
            r_hdr_done  <= 1'b0;
            r_data_done <= 1'b0;
         end else begin
            if (w_hdr_hs)  r_hdr_done  <= 1'b1;
            if (w_data_hs) r_data_done <= 1'b1;
         end
      end
   end

   bp_me_stream_beat_counter #(
      .data_width_p (data_width_p),
      .block_width_p(block_width_p)
   ) u_beat_counter (
      .i_clk    (clk_i),
      .i_rst_n  (reset_n_i),
      .i_size   (w_hdr_lo.msg_size),
      .i_inc    (w_data_hs),
      .i_clr    (in_msg_last_i),
      .o_cnt    (w_cnt),
      .o_is_last(w_is_last)
   );

   assign in_msg_ready_and_o = w_in_rdy;
   assign out_msg_header_o   = in_msg_header_i;
   assign out_msg_header_v_o = w_hdr_v;
   assign out_msg_has_data_o = w_has_data;
   assign out_msg_data_o     = in_msg_data_i;
   assign out_msg_data_v_o   = w_data_v;
   assign out_msg_last_o     = in_msg_last_i & w_data_v;

`ifdef BP_ME_STREAM_TO_BURST_CHECK_EN
   logic [bp_header_width_lp-1:0] r_first_hdr;
   logic                          r_error;
   logic                          w_err_last, w_err_hdr, w_err_nolast;
   logic                          w_unused_cnt;

   assign w_err_last   = w_data_hs & (in_msg_last_i != w_is_last);
   assign w_err_hdr    = (r_state == e_stream) & w_in_v & (in_msg_header_i != r_first_hdr);
   assign w_err_nolast = (r_state == e_first) & w_in_v & ~w_has_data & ~in_msg_last_i;
   assign w_unused_cnt = ^w_cnt;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_first_hdr <= '0;
         r_error     <= 1'b0;
      end else begin
         if ((r_state == e_first) & w_in_hs) r_first_hdr <= in_msg_header_i;
         r_error <= r_error | w_err_last | w_err_hdr | w_err_nolast;
      end
   end

   assign error_o = r_error;
`else
   logic w_unused_cnt;
   assign w_unused_cnt = ^{w_cnt, w_is_last};
`endif

endmodule

// File: tb/tb_bp_me_stream_to_burst.sv
// Directed bench for bp_me_stream_to_burst with a header/data scoreboard; checks error_o when
// BP_ME_STREAM_TO_BURST_CHECK_EN is defined.
module tb_bp_me_stream_to_burst;

   localparam int HW = 8 + 40 + 7;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [HW-1:0] in_hdr;
   logic [63:0]   in_data;
   logic          in_v, in_last, in_rdy;
   logic [HW-1:0] out_hdr;
   logic          hdr_v, has_data, hdr_rdy;
   logic [63:0]   out_data;
   logic          data_v, out_last, data_rdy;
`ifdef BP_ME_STREAM_TO_BURST_CHECK_EN
   logic          error_o;
`endif

   int errors = 0;
   int checks = 0;
   int hdr_hs_cnt = 0;
   int data_hs_cnt = 0;
   logic tog = 1'b0;

   logic [HW:0] exp_hdr_q[$];
   logic [64:0] exp_data_q[$];

   always #5 clk = ~clk;

   bp_me_stream_to_burst #(
      .data_width_p   (64),
      .payload_width_p(8),
      .block_width_p  (512),
      .payload_mask_p (16'h000A)
   ) dut (
      .clk_i                     (clk),
      .reset_n_i                 (reset_n),
      .in_msg_header_i           (in_hdr),
      .in_msg_data_i             (in_data),
      .in_msg_v_i                (in_v),
      .in_msg_last_i             (in_last),
      .in_msg_ready_and_o        (in_rdy),
      .out_msg_header_o          (out_hdr),
      .out_msg_header_v_o        (hdr_v),
      .out_msg_has_data_o        (has_data),
      .out_msg_header_ready_and_i(hdr_rdy),
      .out_msg_data_o            (out_data),
      .out_msg_data_v_o          (data_v),
      .out_msg_last_o            (out_last),
`ifdef BP_ME_STREAM_TO_BURST_CHECK_EN
      .error_o                   (error_o),
`endif
      .out_msg_data_ready_and_i  (data_rdy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz,
                                            input logic [39:0] a);
      return {8'hA5, a, sz, t};
   endfunction

   // Scoreboard: every burst handshake must match the oldest expectation.
   always @(negedge clk) begin
      logic [HW:0] eh;
      logic [64:0] ed;
      if (hdr_v && hdr_rdy) begin
         hdr_hs_cnt++;
         chk("hdr_expected", 64'(exp_hdr_q.size() != 0), 64'd1);
         if (exp_hdr_q.size() != 0) begin
            eh = exp_hdr_q.pop_front();
            chk("hdr_value", 64'(out_hdr), 64'(eh[HW-1:0]));
            chk("has_data", 64'(has_data), 64'(eh[HW]));
         end
      end
      if (data_v && data_rdy) begin
         data_hs_cnt++;
         chk("data_expected", 64'(exp_data_q.size() != 0), 64'd1);
         if (exp_data_q.size() != 0) begin
            ed = exp_data_q.pop_front();
            chk("data_value", out_data, ed[63:0]);
            chk("data_last", 64'(out_last), 64'(ed[64]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one beat and hold it until accepted; waited counts the stalled cycles.
   task automatic send_beat(input logic [HW-1:0] h, input logic [63:0] d, input logic l,
                            output int waited);
      in_v = 1'b1; in_hdr = h; in_data = d; in_last = l;
      waited = 0;
      while (1) begin
         @(negedge clk);
         if (in_rdy) break;
         waited++;
         if (waited > 40) begin
            chk("in_rdy_timeout", 64'(in_rdy), 64'd1);
            break;
         end
         tick();
         if (tog) data_rdy = ~data_rdy;
      end
      tick();
      if (tog) data_rdy = ~data_rdy;
   endtask

   initial begin
      logic [HW-1:0] h;
      int w, hs0, ds0;

      reset_n = 1'b0; in_v = 1'b0; in_last = 1'b0; in_hdr = '0; in_data = '0;
      hdr_rdy = 1'b0; data_rdy = 1'b0;
      tick(); tick();
      chk("rst_hdr_v", 64'(hdr_v), 64'd0);
      chk("rst_data_v", 64'(data_v), 64'd0);
      chk("rst_in_rdy", 64'(in_rdy), 64'd0);
      @(negedge clk); reset_n = 1'b1;
      tick();
      chk("idle_in_rdy", 64'(in_rdy), 64'd0);

      // 64B write, both readies high: 1 header, 8 beats, never stalls
      hdr_rdy = 1'b1; data_rdy = 1'b1;
      h = mk_hdr(4'd1, 3'd6, 40'h1000);
      exp_hdr_q.push_back({1'b1, h});
      hs0 = hdr_hs_cnt;
      for (int i = 0; i < 8; i++) begin
         exp_data_q.push_back({i == 7, 64'(i)});
         send_beat(h, 64'(i), i == 7, w);
         chk("wr64_no_stall", 64'(w), 64'd0);
         if (i == 2) chk("wr64_stream_hdr_v", 64'(hdr_v), 64'd0);
      end
      in_v = 1'b0;
      chk("wr64_hdr_once", 64'(hdr_hs_cnt - hs0), 64'd1);

      // Read request: header only
      h = mk_hdr(4'd0, 3'd6, 40'h2000);
      exp_hdr_q.push_back({1'b0, h});
      in_v = 1'b1; in_hdr = h; in_data = 64'hDEAD; in_last = 1'b1;
      @(negedge clk);
      chk("rd_hdr_v", 64'(hdr_v), 64'd1);
      chk("rd_has_data", 64'(has_data), 64'd0);
      chk("rd_data_v", 64'(data_v), 64'd0);
      chk("rd_in_rdy", 64'(in_rdy), 64'd1);
      tick();
      in_v = 1'b0;

      // Header stalled 3 cycles, data accepted at once and not replayed
      hdr_rdy = 1'b0; data_rdy = 1'b1;
      h = mk_hdr(4'd3, 3'd3, 40'h3000);
      exp_hdr_q.push_back({1'b1, h});
      exp_data_q.push_back({1'b1, 64'h55});
      ds0 = data_hs_cnt;
      in_v = 1'b1; in_hdr = h; in_data = 64'h55; in_last = 1'b1;
      @(negedge clk);
      chk("hs_c0_data_v", 64'(data_v), 64'd1);
      chk("hs_c0_in_rdy", 64'(in_rdy), 64'd0);
      tick(); @(negedge clk);
      chk("hs_c1_data_v", 64'(data_v), 64'd0);
      chk("hs_c1_hdr_v", 64'(hdr_v), 64'd1);
      chk("hs_c1_in_rdy", 64'(in_rdy), 64'd0);
      tick(); @(negedge clk);
      chk("hs_c2_in_rdy", 64'(in_rdy), 64'd0);
      tick(); hdr_rdy = 1'b1; @(negedge clk);
      chk("hs_c3_in_rdy", 64'(in_rdy), 64'd1);
      tick();
      in_v = 1'b0;
      chk("hs_one_data", 64'(data_hs_cnt - ds0), 64'd1);

      // 4-beat message with data ready toggling every cycle
      h = mk_hdr(4'd1, 3'd5, 40'h4000);
      exp_hdr_q.push_back({1'b1, h});
      hs0 = hdr_hs_cnt; ds0 = data_hs_cnt;
      tog = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_data_q.push_back({i == 3, 64'(32'hA0 + i)});
         send_beat(h, 64'(32'hA0 + i), i == 3, w);
      end
      in_v = 1'b0; tog = 1'b0; data_rdy = 1'b1;
      chk("tog_hdr_once", 64'(hdr_hs_cnt - hs0), 64'd1);
      chk("tog_data_cnt", 64'(data_hs_cnt - ds0), 64'd4);

      // Async reset at beat 2 of 8
      h = mk_hdr(4'd1, 3'd6, 40'h5000);
      exp_hdr_q.push_back({1'b1, h});
      for (int i = 0; i < 2; i++) begin
         exp_data_q.push_back({1'b0, 64'(32'h100 + i)});
         send_beat(h, 64'(32'h100 + i), 1'b0, w);
      end
      in_data = 64'h102;
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_hdr_v", 64'(hdr_v), 64'd0);
      chk("mid_rst_data_v", 64'(data_v), 64'd0);
      chk("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
      in_v = 1'b0;
      tick();
      @(negedge clk); reset_n = 1'b1;
      tick();
      h = mk_hdr(4'd0, 3'd3, 40'h6000);
      exp_hdr_q.push_back({1'b0, h});
      in_v = 1'b1; in_hdr = h; in_last = 1'b1;
      #1;
      chk("post_rst_hdr_v", 64'(hdr_v), 64'd1);
      chk("post_rst_data_v", 64'(data_v), 64'd0);
      send_beat(h, 64'h0, 1'b1, w);
      in_v = 1'b0;

`ifdef BP_ME_STREAM_TO_BURST_CHECK_EN
      chk("err_clean", 64'(error_o), 64'd0);
      h = mk_hdr(4'd1, 3'd6, 40'h7000);
      exp_hdr_q.push_back({1'b1, h});
      for (int i = 0; i < 5; i++) begin
         exp_data_q.push_back({i == 4, 64'(32'h200 + i)});
         send_beat(h, 64'(32'h200 + i), i == 4, w);
         if (i == 3) chk("err_before_last", 64'(error_o), 64'd0);
      end
      in_v = 1'b0;
      chk("err_set", 64'(error_o), 64'd1);
      tick(); tick(); tick();
      chk("err_sticky", 64'(error_o), 64'd1);
      @(negedge clk); reset_n = 1'b0;
      #1;
      chk("err_cleared", 64'(error_o), 64'd0);
      @(negedge clk); reset_n = 1'b1;
`endif

      tick(); tick();
      chk("hdr_q_drained", 64'(exp_hdr_q.size()), 64'd0);
      chk("data_q_drained", 64'(exp_data_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
